// File: rtl/collatz_pkg.sv
// Shared types for the Collatz trajectory engine: FSM states and run status codes.
// Pure declarations; no timing or flow control of its own.
package collatz_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ST_OK   = 2'b00,
    ST_ZERO = 2'b01,
    ST_OVF  = 2'b10,
    ST_SAT  = 2'b11
  } status_t;

endpackage

// File: rtl/collatz_engine_param_if.sv
// Control/result bundle between the pin wrapper (master) and the engine (slave).
// Level-based start/abort, no handshake back-pressure; ena freezes the whole slave.
interface collatz_engine_param_if
  import collatz_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int STEPS_W = 16
);
  logic               ena;
  logic               start;
  logic               abort;
  logic               shortcut;
  logic [WIDTH-1:0]   seed;
  logic               busy;
  logic               done;
  logic [STEPS_W-1:0] steps;
  logic [WIDTH-1:0]   peak;
  status_t            status;

  modport master (
    output ena, start, abort, shortcut, seed,
    input  busy, done, steps, peak, status
  );

  modport slave (
    input  ena, start, abort, shortcut, seed,
    output busy, done, steps, peak, status
  );
endinterface

// File: rtl/collatz_step.sv
// One Collatz map application on n, optionally the (3n+1)/2 shortcut for odd n.
// Purely combinational; 3n+1 is formed in WIDTH+2 bits so overflow is never lost.
module collatz_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] n,
  input  logic             shortcut,
  output logic [WIDTH-1:0] n_next,
  output logic             ovf,
  output logic             is_one,
  output logic             is_even
);

  logic [WIDTH+1:0] t;

  always_comb begin
    t       = {2'b00, n} + {1'b0, n, 1'b0} + {{(WIDTH+1){1'b0}}, 1'b1};
    is_even = ~n[0];
    is_one  = (n == {{(WIDTH-1){1'b0}}, 1'b1});
    ovf     = ~is_even & (|t[WIDTH+1:WIDTH]);
    if (is_even) begin
      n_next = n >> 1;
    end else if (shortcut) begin
      n_next = t[WIDTH:1];
    end else begin
      n_next = t[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/collatz_engine_param.sv
// Collatz trajectory engine: one map step per enabled clock, reports steps/peak/status.
// Start to done = steps+2 enabled cycles (zero seed: 1); ena low stalls every register.
module collatz_engine_param
  import collatz_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int STEPS_W = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  collatz_engine_param_if.slave bus
);

  state_t             state_q, state_d;
  status_t            status_q, status_d;
  logic [WIDTH-1:0]   n_q, n_d;
  logic [WIDTH-1:0]   peak_q, peak_d;
  logic [STEPS_W-1:0] steps_q, steps_d;
  logic               mode_q, mode_d;

  logic [WIDTH-1:0] n_next;
  logic             ovf;
  logic             is_one;
  logic             is_even;

  collatz_step #(.WIDTH(WIDTH)) u_step (
    .n        (n_q),
    .shortcut (mode_q),
    .n_next   (n_next),
    .ovf      (ovf),
    .is_one   (is_one),
    .is_even  (is_even)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      status_q <= ST_OK;
      n_q      <= '0;
      peak_q   <= '0;
      steps_q  <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      n_q      <= n_d;
      peak_q   <= peak_d;
      steps_q  <= steps_d;
      mode_q   <= mode_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    n_d      = n_q;
    peak_d   = peak_q;
    steps_d  = steps_q;
    mode_d   = mode_q;

    if (bus.ena) begin
      // abort outranks start; partial steps/peak are left visible
      if (bus.abort) begin
        state_d  = IDLE;
        status_d = ST_OK;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (bus.start) begin
              n_d      = bus.seed;
              peak_d   = bus.seed;
              steps_d  = '0;
              mode_d   = bus.shortcut;
              if (bus.seed == '0) begin
                state_d  = DONE;
                status_d = ST_ZERO;
              end else begin
                state_d  = RUN;
                status_d = ST_OK;
              end
            end
          end
          RUN: begin
            if (is_one) begin
              state_d  = DONE;
              status_d = ST_OK;
            end else if (&steps_q) begin
              state_d  = DONE;
              status_d = ST_SAT;
            end else if (!is_even && ovf) begin
              state_d  = DONE;
              status_d = ST_OVF;
            end else begin
              n_d     = n_next;
              steps_d = steps_q + STEPS_W'(1);
              if (n_next > peak_q) begin
                peak_d = n_next;
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.steps  = steps_q;
  assign bus.peak   = peak_q;
  assign bus.status = status_q;

endmodule
